// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   WORD_W / BE_W : data word width and number of byte lanes
//   ALIGN_MASK    : byte-address bits that must be zero for a word access
//   state_e       : responder FSM states (idle, wait states, response)
//   addr_err()    : misaligned or out-of-range check for a byte address
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [WORD_W-1:0] ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // An access is rejected when it is not word aligned or its word index
    // lies beyond the end of the array.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr,
                                      input int unsigned       depth_words);
        logic [WORD_W-1:0] word_idx;
        word_idx = addr >> 2;
        return ((addr & ALIGN_MASK) != '0) || (word_idx >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word array with per-lane write enables
// and a registered read port.
//   clk, rst : clock; rst clears only the read-data register, not the array
//   en       : perform an access this cycle
//   wr       : 1 = write enabled lanes, 0 = read word into rdata
//   lane_we  : byte-lane write enables (lane i -> bits 8i+7:8i)
//   idx      : word index
//   wdata    : write data
//   rd_clr   : force the read-data register to zero (stores and errors)
//   rdata    : registered read data; holds until the next read or clear
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [BE_W-1:0]   lane_we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic              rd_clr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en && wr) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (lane_we[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_clr) begin
            rdata <= '0;
        end else if (en && !wr) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: memory-side responder for the CPU data-memory port.
// Accepts one load/store over a valid/ready handshake, waits WAIT_CYCLES
// cycles, commits the access to a word array and returns read data and an
// error flag over a second valid/ready handshake. Requests are never queued.
//
// Build option: DMEM_RESP_BYTE_EN - when defined, stores write only the byte
// lanes selected by req_be; otherwise req_be is ignored and stores write the
// whole word.
//
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   req_valid   : request present          req_ready  : accepting (idle only)
//   req_we      : 1 = store, 0 = load      req_addr   : byte address
//   req_wdata   : store data               req_be     : byte-lane enables
//   resp_valid  : response present         resp_ready : requester takes it
//   resp_rdata  : load data, 0 for stores/errors
//   resp_err    : misaligned or out-of-range access
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic              commit;

    logic              arr_en;
    logic              arr_clr;
    logic [BE_W-1:0]   lane_we;

    // Next-state and commit decode. The counter is loaded on accept and the
    // commit happens on the edge where WAIT sees it at zero, so WAIT_CYCLES=0
    // still spends exactly one cycle in WAIT.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        commit       = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    we_d    = req_we;
                    idx_d   = req_addr[IDX_W+1:2];
                    wdata_d = req_wdata;
                    err_d   = addr_err(req_addr, DEPTH_WORDS);
                    cnt_d   = CNT_INIT;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    commit       = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_q;
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

`ifdef DMEM_RESP_BYTE_EN
    logic [BE_W-1:0] be_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            be_q <= '0;
        end else if (state_q == StIdle && req_valid) begin
            be_q <= req_be;
        end
    end

    assign lane_we = be_q;
`else
    logic unused_be;

    assign unused_be = ^req_be;
    assign lane_we   = '1;
`endif

    // Errored accesses never touch the array; stores and errors zero rdata.
    assign arr_en  = commit && !err_q;
    assign arr_clr = commit && (err_q || we_q);

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .en     (arr_en),
        .wr     (we_q),
        .lane_we(lane_we),
        .idx    (idx_q),
        .wdata  (wdata_q),
        .rd_clr (arr_clr),
        .rdata  (resp_rdata)
    );

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;

endmodule
